// File: rtl/cse_bubble_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : cse_bubble_pkg
//  Description : Shared defaults and FSM state encoding for the CSE_Bubble
//                in-place bubble-sort sequencer.
//  Contents    : CSE_DATA_W / CSE_DEPTH / CSE_ADDR_W default sizes,
//                STATE_W-bit state encodings, busy-state helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package cse_bubble_pkg;

  localparam int CSE_DATA_W = 32;
  localparam int CSE_DEPTH  = 10;
  localparam int CSE_ADDR_W = 4;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
  localparam logic [STATE_W-1:0] ST_RD_A = 3'd1;
  localparam logic [STATE_W-1:0] ST_RD_B = 3'd2;
  localparam logic [STATE_W-1:0] ST_CMP  = 3'd3;
  localparam logic [STATE_W-1:0] ST_WR_A = 3'd4;
  localparam logic [STATE_W-1:0] ST_WR_B = 3'd5;
  localparam logic [STATE_W-1:0] ST_DONE = 3'd6;

  // The sort owns the memory in every state from RD_A through WR_B.
  function automatic logic is_sort_state(input logic [STATE_W-1:0] s);
    return (s >= ST_RD_A) && (s <= ST_WR_B);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cmp_swap_unit.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_swap_unit
//  Description : Combinational unsigned compare of an adjacent element pair
//                and the pair re-ordered ascending.
//  Ports       : a, b      in  DATA_W  element at j and element at j+1
//                gt        out 1       a > b (unsigned) -> pair must swap
//                lo, hi    out DATA_W  smaller / larger element of the pair
//  Revision    : 1.0 - initial release
// ============================================================================
module cmp_swap_unit #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              gt,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] hi
);

  // Strict greater-than: equal elements stay in place, keeping the sort stable.
  assign gt = (a > b);
  assign lo = gt ? b : a;
  assign hi = gt ? a : b;

endmodule
`default_nettype wire

// File: rtl/bubble_sort_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : bubble_sort_sequencer
//  Description : FSM controller running an in-place ascending bubble sort on
//                the CSE_Bubble data memory. Per element pair it sequences
//                read j / read j+1 / compare / write j / write j+1 (writes only
//                when the pair is out of order).
//  Ports       : clock       in  1       rising-edge clock
//                reset       in  1       asynchronous, active-low
//                start       in  1       one-cycle request, honoured in IDLE only
//                array_size  in  DATA_W  element count, clamped to DEPTH
//                busy        out 1       sorting in progress
//                done        out 1       one-cycle completion pulse
//                mem_addr    out ADDR_W  memory address
//                mem_rd_en   out 1       read strobe (data returns next cycle)
//                mem_wr_en   out 1       write strobe
//                mem_wdata   out DATA_W  write data
//                mem_rdata   in  DATA_W  synchronous read data
//  Config      : SORT_EARLY_EXIT_EN - when defined, finish after the first
//                pass that made no swap; otherwise always run n-1 passes.
//  Revision    : 1.0 - initial release
// ============================================================================
module bubble_sort_sequencer
  import cse_bubble_pkg::*;
#(
  parameter int DATA_W = CSE_DATA_W,
  parameter int DEPTH  = CSE_DEPTH,
  parameter int ADDR_W = CSE_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] array_size,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // One extra bit so the element count itself (up to DEPTH) is representable.
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [DATA_W-1:0] DEPTH_D = DATA_W'(DEPTH);
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_nx;

  logic [CNT_W-1:0]  n_cnt;      // latched, clamped element count
  logic [ADDR_W-1:0] j;          // index of the left element of the pair
  logic [ADDR_W-1:0] pass;       // completed passes
  logic              swapped;    // a swap happened in the current pass
  logic [DATA_W-1:0] a_val;      // element j captured from the first read
  logic [DATA_W-1:0] lo_val;     // value written back to j
  logic [DATA_W-1:0] hi_val;     // value written back to j+1

  logic [CNT_W-1:0]  size_clamped;
  logic              gt;
  logic [DATA_W-1:0] pair_lo;
  logic [DATA_W-1:0] pair_hi;
  logic              last_cmp;
  logic              last_pass;
  logic              finish_sort;
  logic              do_advance;
  logic [STATE_W-1:0] adv_state;

  assign size_clamped = (array_size > DEPTH_D) ? DEPTH_C : array_size[CNT_W-1:0];

  // In CMP, mem_rdata carries element j+1 from the read issued in RD_B.
  cmp_swap_unit #(
    .DATA_W (DATA_W)
  ) u_cmp_swap (
    .a  (a_val),
    .b  (mem_rdata),
    .gt (gt),
    .lo (pair_lo),
    .hi (pair_hi)
  );

  // Pass p compares pairs j = 0 .. n-2-p; the final pass is p = n-2.
  // n >= 2 whenever these are consulted, so the subtractions never wrap.
  assign last_cmp  = ({1'b0, j} == (n_cnt - CNT_W'(2) - {1'b0, pass}));
  assign last_pass = ({1'b0, pass} == (n_cnt - CNT_W'(2)));

`ifdef SORT_EARLY_EXIT_EN
  // A pass without any swap proves the array is already ordered.
  assign finish_sort = last_cmp && (last_pass || !swapped);
`else
  assign finish_sort = last_cmp && last_pass;
`endif

  // A pair is finished after a non-swapping compare or after its second write.
  assign do_advance = ((state == ST_CMP) && !gt) || (state == ST_WR_B);
  assign adv_state  = finish_sort ? ST_DONE : ST_RD_A;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx = (size_clamped <= CNT_W'(1)) ? ST_DONE : ST_RD_A;
        end
      end
      ST_RD_A: state_nx = ST_RD_B;
      ST_RD_B: state_nx = ST_CMP;
      ST_CMP:  state_nx = gt ? ST_WR_A : adv_state;
      ST_WR_A: state_nx = ST_WR_B;
      ST_WR_B: state_nx = adv_state;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic (Moore: decoded from the current state only)
  // --------------------------------------------------------------------------
  always_comb begin
    busy      = is_sort_state(state);
    done      = (state == ST_DONE);
    mem_addr  = '0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_wdata = '0;
    case (state)
      ST_RD_A: begin
        mem_addr  = j;
        mem_rd_en = 1'b1;
      end
      ST_RD_B: begin
        mem_addr  = j + ADDR_W'(1);
        mem_rd_en = 1'b1;
      end
      ST_WR_A: begin
        mem_addr  = j;
        mem_wdata = lo_val;
        mem_wr_en = 1'b1;
      end
      ST_WR_B: begin
        mem_addr  = j + ADDR_W'(1);
        mem_wdata = hi_val;
        mem_wr_en = 1'b1;
      end
      default: begin
        mem_addr  = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Counters and pair datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      n_cnt   <= '0;
      j       <= '0;
      pass    <= '0;
      swapped <= 1'b0;
      a_val   <= '0;
      lo_val  <= '0;
      hi_val  <= '0;
    end else begin
      if ((state == ST_IDLE) && start) begin
        n_cnt   <= size_clamped;
        j       <= '0;
        pass    <= '0;
        swapped <= 1'b0;
      end

      if (state == ST_RD_B) begin
        a_val <= mem_rdata;
      end

      if ((state == ST_CMP) && gt) begin
        lo_val  <= pair_lo;
        hi_val  <= pair_hi;
        swapped <= 1'b1;
      end

      if (do_advance) begin
        if (!last_cmp) begin
          j <= j + ADDR_W'(1);
        end else begin
          j       <= '0;
          pass    <= pass + ADDR_W'(1);
          swapped <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bubble_sort_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bubble_sort_sequencer
//  Description : Self-checking bench for bubble_sort_sequencer with a
//                synchronous memory model and a sorting reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bubble_sort_sequencer;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 10;
  localparam int ADDR_W = 4;
  localparam int LIMIT  = 2000;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [DATA_W-1:0] array_size = '0;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic              mem_wr_en;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;

  logic [DATA_W-1:0] mem [16];
  logic              ld_en = 1'b0;
  logic [ADDR_W-1:0] ld_addr = '0;
  logic [DATA_W-1:0] ld_data = '0;

  logic [DATA_W-1:0] init_mem [DEPTH];
  logic [DATA_W-1:0] exp_mem  [DEPTH];

  int compared   = 0;
  int mismatched = 0;
  int wr_count   = 0;
  int both_high  = 0;

  int busy_cyc, done_cyc, first_done, busy_after, done_after, wr_before;
  bit timeout;

  always #5 clock = ~clock;

  bubble_sort_sequencer #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .array_size (array_size),
    .busy       (busy),
    .done       (done),
    .mem_addr   (mem_addr),
    .mem_rd_en  (mem_rd_en),
    .mem_wr_en  (mem_wr_en),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Synchronous-read memory; the bench preloads it through the ld_* port.
  always @(posedge clock) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
    if (mem_wr_en) begin
      mem[mem_addr] <= mem_wdata;
      wr_count      <= wr_count + 1;
    end else if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end
  end

  always @(negedge clock) if (mem_rd_en && mem_wr_en) both_high <= both_high + 1;

  // ---------------- reference model ----------------
  function automatic int count_inv(input int n);
    int c = 0;
    for (int i = 0; i < n; i++)
      for (int k = 0; k < i; k++)
        if (init_mem[k] > init_mem[i]) c++;
    return c;
  endfunction

  // Busy cycles = 3 per compare + 2 extra per swap. Swaps equal inversions.
  // Each pass lowers every element's "greater-on-left" count by one, so the
  // data is ordered after max(count) passes; early exit adds one clean pass.
  function automatic int model_busy(input int n);
    int inv, maxl, left, passes, cmps;
    if (n < 2) return 0;
    inv  = count_inv(n);
    maxl = 0;
    for (int i = 0; i < n; i++) begin
      left = 0;
      for (int k = 0; k < i; k++) if (init_mem[k] > init_mem[i]) left++;
      if (left > maxl) maxl = left;
    end
    passes = n - 1;
`ifdef SORT_EARLY_EXIT_EN
    if (maxl + 1 < passes) passes = maxl + 1;
`endif
    cmps = 0;
    for (int p = 0; p < passes; p++) cmps += n - 1 - p;
    return 3 * cmps + 2 * inv;
  endfunction

  function automatic void build_expect(input int n);
    bit [DATA_W-1:0] q[$];
    for (int i = 0; i < n; i++) q.push_back(init_mem[i]);
    q.sort();
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = (i < n) ? q[i] : init_mem[i];
  endfunction

  function automatic int clamp(input int size);
    return (size > DEPTH) ? DEPTH : size;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic load_mem();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clock);
      ld_en = 1'b1; ld_addr = ADDR_W'(i); ld_data = init_mem[i];
    end
    @(negedge clock);
    ld_en = 1'b0;
  endtask

  task automatic fill_random(input int maxv);
    for (int i = 0; i < DEPTH; i++)
      init_mem[i] = (maxv == 0) ? $urandom : DATA_W'($urandom_range(0, maxv));
  endtask

  // Starts a sort and records busy/done timing; start can be re-pulsed
  // mid-sort (pulse_at) or in the done cycle (pulse_in_done).
  task automatic drive_sort(input int size, input int pulse_at, input bit pulse_in_done);
    int k;
    bit seen;
    busy_cyc = 0; done_cyc = 0; first_done = -1; busy_after = 0; done_after = 0;
    timeout = 0; seen = 0;
    wr_before = wr_count;
    @(negedge clock);
    array_size = DATA_W'(size); start = 1'b1;
    @(negedge clock);
    start = 1'b0; array_size = $urandom;
    k = 0;
    while (!seen && k < LIMIT) begin
      if (busy) busy_cyc++;
      if (done) begin
        done_cyc++; first_done = k; seen = 1;
        if (pulse_in_done) begin start = 1'b1; array_size = 32'd2; end
      end else if (k == pulse_at) begin
        start = 1'b1; array_size = DATA_W'($urandom_range(2, 10));
      end
      @(negedge clock);
      start = 1'b0;
      k++;
    end
    timeout = !seen;
    repeat (2) begin
      if (busy) busy_after++;
      if (done) done_after++;
      @(negedge clock);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    compared++;
    if ({busy, done, mem_rd_en, mem_wr_en} !== 4'b0000) begin
      mismatched++;
      $display("FAIL reset_ctrl: got %b expected 0000", {busy, done, mem_rd_en, mem_wr_en});
    end
    compared++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      mismatched++;
      $display("FAIL reset_bus: addr %0d wdata %0d expected 0/0", mem_addr, mem_wdata);
    end
  endtask

  task automatic test_reset_mid_sort();
    int snap;
    init_mem = '{5, 4, 3, 2, 1, 9, 9, 9, 9, 9};
    load_mem();
    @(negedge clock); array_size = 32'd5; start = 1'b1;
    @(negedge clock); start = 1'b0;
    repeat (12) @(negedge clock);
    reset = 1'b0;
    #1;
    compared++;
    if ({busy, done, mem_rd_en, mem_wr_en} !== 4'b0000) begin
      mismatched++;
      $display("FAIL midreset_outputs: got %b expected 0000", {busy, done, mem_rd_en, mem_wr_en});
    end
    snap = wr_count;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (4) @(negedge clock);
    compared++;
    if (wr_count !== snap || busy !== 1'b0 || done !== 1'b0) begin
      mismatched++;
      $display("FAIL midreset_quiet: writes %0d busy %b done %b expected %0d/0/0",
               wr_count - snap, busy, done, 0);
    end
  endtask

  task automatic test_pair();
    fill_random(0);
    init_mem[0] = 2; init_mem[1] = 1;
    load_mem(); build_expect(2);
    drive_sort(2, -1, 0);
    compared++;
    if (timeout || busy_cyc !== 5) begin
      mismatched++;
      $display("FAIL pair_busy: got %0d (timeout %0d) expected 5", busy_cyc, timeout);
    end
    compared++;
    if (done_cyc !== 1 || done_after !== 0 || busy_after !== 0) begin
      mismatched++;
      $display("FAIL pair_done_pulse: got %0d+%0d expected 1+0", done_cyc, done_after);
    end
    for (int i = 0; i < DEPTH; i++) begin
      compared++;
      if (mem[i] !== exp_mem[i]) begin
        mismatched++;
        $display("FAIL pair_mem[%0d]: got %0d expected %0d", i, mem[i], exp_mem[i]);
      end
    end
  endtask

  task automatic test_reverse();
    init_mem = '{5, 4, 3, 2, 1, 77, 66, 55, 44, 33};
    load_mem(); build_expect(5);
    drive_sort(5, -1, 0);
    compared++;
    if (timeout || busy_cyc !== model_busy(5)) begin
      mismatched++;
      $display("FAIL reverse_busy: got %0d expected %0d", busy_cyc, model_busy(5));
    end
    compared++;
    if (wr_count - wr_before !== 20) begin
      mismatched++;
      $display("FAIL reverse_writes: got %0d expected 20", wr_count - wr_before);
    end
    for (int i = 0; i < DEPTH; i++) begin
      compared++;
      if (mem[i] !== exp_mem[i]) begin
        mismatched++;
        $display("FAIL reverse_mem[%0d]: got %0d expected %0d", i, mem[i], exp_mem[i]);
      end
    end
  endtask

  task automatic test_presorted();
    for (int i = 0; i < DEPTH; i++) init_mem[i] = DATA_W'(i + 1);
    load_mem();
    drive_sort(10, -1, 0);
    compared++;
    if (timeout || busy_cyc !== model_busy(10)) begin
      mismatched++;
      $display("FAIL presorted_busy: got %0d expected %0d", busy_cyc, model_busy(10));
    end
    compared++;
    if (wr_count !== wr_before) begin
      mismatched++;
      $display("FAIL presorted_writes: got %0d expected 0", wr_count - wr_before);
    end
  endtask

  task automatic test_size_bounds();
    int sizes[3] = '{0, 1, 15};
    for (int s = 0; s < 3; s++) begin
      fill_random(0);
      load_mem(); build_expect(clamp(sizes[s]));
      drive_sort(sizes[s], -1, 0);
      compared++;
      if (sizes[s] <= 1 && (first_done !== 0 || busy_cyc !== 0 || wr_count !== wr_before)) begin
        mismatched++;
        $display("FAIL size%0d_trivial: done at %0d busy %0d expected 0/0", sizes[s], first_done, busy_cyc);
      end else if (sizes[s] > 1 && (timeout || busy_cyc !== model_busy(DEPTH))) begin
        mismatched++;
        $display("FAIL size%0d_busy: got %0d expected %0d", sizes[s], busy_cyc, model_busy(DEPTH));
      end
      for (int i = 0; i < DEPTH; i++) begin
        compared++;
        if (mem[i] !== exp_mem[i]) begin
          mismatched++;
          $display("FAIL size%0d_mem[%0d]: got %0d expected %0d", sizes[s], i, mem[i], exp_mem[i]);
        end
      end
    end
  endtask

  task automatic test_start_while_busy();
    init_mem = '{3, 3, 1, 8, 7, 6, 5, 4, 3, 2};
    load_mem(); build_expect(3);
    drive_sort(3, 3, 0);
    compared++;
    if (timeout || busy_cyc !== 13 || busy_after !== 0) begin
      mismatched++;
      $display("FAIL busy_start_busy: got %0d/%0d expected 13/0", busy_cyc, busy_after);
    end
    compared++;
    if (wr_count - wr_before !== 4) begin
      mismatched++;
      $display("FAIL busy_start_writes: got %0d expected 4", wr_count - wr_before);
    end
    for (int i = 0; i < DEPTH; i++) begin
      compared++;
      if (mem[i] !== exp_mem[i]) begin
        mismatched++;
        $display("FAIL busy_start_mem[%0d]: got %0d expected %0d", i, mem[i], exp_mem[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    fill_random(15);
    load_mem(); build_expect(6);
    drive_sort(6, -1, 1);
    compared++;
    if (timeout || busy_cyc !== model_busy(6) || busy_after !== 0 || done_after !== 0) begin
      mismatched++;
      $display("FAIL b2b_done_start: busy %0d after %0d/%0d expected %0d 0/0",
               busy_cyc, busy_after, done_after, model_busy(6));
    end
    for (int i = 0; i < DEPTH; i++) init_mem[i] = mem[i];
    init_mem[0] = 32'hFFFF_FFF0; init_mem[1] = 32'h0000_0010;
    load_mem(); build_expect(8);
    drive_sort(8, -1, 0);
    compared++;
    if (timeout || busy_cyc !== model_busy(8)) begin
      mismatched++;
      $display("FAIL b2b_second_busy: got %0d expected %0d", busy_cyc, model_busy(8));
    end
    for (int i = 0; i < DEPTH; i++) begin
      compared++;
      if (mem[i] !== exp_mem[i]) begin
        mismatched++;
        $display("FAIL b2b_mem[%0d]: got %0h expected %0h", i, mem[i], exp_mem[i]);
      end
    end
  endtask

  task automatic test_random();
    int n;
    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(2, 12);
      fill_random((t % 2 == 0) ? 7 : 0);
      load_mem(); build_expect(clamp(n));
      drive_sort(n, -1, 0);
      compared++;
      if (timeout || busy_cyc !== model_busy(clamp(n)) ||
          wr_count - wr_before !== 2 * count_inv(clamp(n))) begin
        mismatched++;
        $display("FAIL rand%0d_timing: busy %0d writes %0d expected %0d/%0d", t, busy_cyc,
                 wr_count - wr_before, model_busy(clamp(n)), 2 * count_inv(clamp(n)));
      end
      for (int i = 0; i < DEPTH; i++) begin
        compared++;
        if (mem[i] !== exp_mem[i]) begin
          mismatched++;
          $display("FAIL rand%0d_mem[%0d]: got %0h expected %0h", t, i, mem[i], exp_mem[i]);
        end
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clock);
    test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    test_reset_mid_sort();
    test_pair();
    test_reverse();
    test_presorted();
    test_size_bounds();
    test_start_while_busy();
    test_back_to_back();
    test_random();
    compared++;
    if (both_high !== 0) begin
      mismatched++;
      $display("FAIL strobe_exclusive: got %0d overlapping cycles expected 0", both_high);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
`default_nettype wire
